// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : audio_pkg
//  Description : Shared types and constants for the audio frame path.
//  Revision    : 1.0  initial release
// ============================================================================
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WAIT_S  = 3'd2,
    WAIT_F  = 3'd3,
    PUBLISH = 3'd4,
    HOLD    = 3'd5,
    ERR     = 3'd6
  } sched_state_t;

  localparam int          FRAME_SAMPLES        = 16;
  localparam logic [19:0] DEFAULT_FRAME_PERIOD = 20'd416667;  // 60 Hz at 25 MHz

  // A frame is in progress in every state except the two resting states.
  function automatic logic sched_busy(input sched_state_t s);
    return (s != IDLE) && (s != ERR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/capture_scheduler_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : N-flop synchronizer for a slow asynchronous flag, with
//                rise/fall detection on the synchronized value.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  // Metastability chain plus one delayed copy of the settled value for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_in};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_out = chain_q[STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;

endmodule
`default_nettype wire

// File: rtl/capture_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : capture_scheduler
//  Description : Frame-level sequencer: arms the mic sampler, launches the
//                spectrum engine on sampler done, publishes one frame per
//                refresh tick. Timeouts park the block in ERR.
//  Revision    : 1.0  initial release
// ============================================================================
module capture_scheduler #(
  parameter int PERIOD_W = 20,
  parameter int SMP_TMO  = 4096,
  parameter int FFT_TMO  = 1024,
  parameter int TMO_W    = 16
) (
  input  logic                clk_25,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] frame_period,
  output logic                smp_start,
  input  logic                smp_done,
  output logic                fft_start,
  input  logic                fft_done,
  output logic                frame_valid,
  output logic                busy,
  output logic                err_tmo,
  output logic [15:0]         frame_cnt
);

  import audio_pkg::*;

  localparam logic [TMO_W-1:0] SMP_LIM = TMO_W'(SMP_TMO - 1);
  localparam logic [TMO_W-1:0] FFT_LIM = TMO_W'(FFT_TMO - 1);

  sched_state_t        state_q, state_d;
  logic [PERIOD_W-1:0] refresh_q;
  logic [PERIOD_W-1:0] reload;
  logic                tick;
  logic [TMO_W-1:0]    tmo_q;
  logic                tmo_clr;
  logic                smp_start_q, smp_start_d;
  logic                fft_start_q, fft_start_d;
  logic                frame_valid_q, frame_valid_d;
  logic                err_q, err_d;
  logic                cnt_inc;
  logic [15:0]         frame_cnt_q;
  logic                done_s, done_rise;
  logic                unused_done_fall;

  sync_edge #(.STAGES(2)) u_done_sync (
    .clk      (clk_25),
    .rst_n    (rst_n),
    .async_in (smp_done),
    .sync_out (done_s),
    .rise     (done_rise),
    .fall     (unused_done_fall)
  );

  // Periods below 2 would tick every cycle or never reload sensibly; clamp to 2.
  assign reload = (frame_period < PERIOD_W'(2)) ? PERIOD_W'(1) : (frame_period - PERIOD_W'(1));
  assign tick   = (refresh_q == '0);

  // Refresh timer: parked at 0 while disabled so the first launch is immediate.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n)            refresh_q <= '0;
    else if (!enable)      refresh_q <= '0;
    else if (tick)         refresh_q <= reload;
    else                   refresh_q <= refresh_q - PERIOD_W'(1);
  end

  // Shared timeout counter, restarted on entry to each waiting state.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n)                                   tmo_q <= '0;
    else if (tmo_clr)                             tmo_q <= '0;
    else if (state_q == WAIT_S || state_q == WAIT_F) tmo_q <= tmo_q + TMO_W'(1);
  end

  // State and registered outputs; the sampler sees a glitch-free smp_start.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      smp_start_q   <= 1'b0;
      fft_start_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      smp_start_q   <= smp_start_d;
      fft_start_q   <= fft_start_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
    end
  end

  // Published-frame counter, free to wrap.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n)       frame_cnt_q <= '0;
    else if (cnt_inc) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  // Next-state logic; done beats timeout in WAIT_S, and fft_done coinciding with
  // the fft_start pulse is ignored because the engine cannot have finished yet.
  always_comb begin
    state_d       = state_q;
    smp_start_d   = smp_start_q;
    fft_start_d   = 1'b0;
    frame_valid_d = 1'b0;
    err_d         = err_q;
    tmo_clr       = 1'b0;
    cnt_inc       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!enable)   err_d   = 1'b0;
        else if (tick) state_d = ARM;
      end
      ARM: begin
        if (!done_s) begin
          smp_start_d = 1'b1;
          tmo_clr     = 1'b1;
          state_d     = WAIT_S;
        end
      end
      WAIT_S: begin
        if (done_rise) begin
          smp_start_d = 1'b0;
          fft_start_d = 1'b1;
          tmo_clr     = 1'b1;
          state_d     = WAIT_F;
        end else if (tmo_q == SMP_LIM) begin
          smp_start_d = 1'b0;
          err_d       = 1'b1;
          state_d     = ERR;
        end
      end
      WAIT_F: begin
        if (fft_done && !fft_start_q) begin
          frame_valid_d = 1'b1;
          cnt_inc       = 1'b1;
          state_d       = PUBLISH;
        end else if (tmo_q == FFT_LIM) begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      PUBLISH: state_d = HOLD;
      HOLD: begin
        if (tick) state_d = enable ? ARM : IDLE;
      end
      ERR: begin
        smp_start_d = 1'b0;
        if (!enable) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign smp_start   = smp_start_q;
  assign fft_start   = fft_start_q;
  assign frame_valid = frame_valid_q;
  assign err_tmo     = err_q;
  assign busy        = sched_busy(state_q);
  assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_capture_scheduler
//  Description : Self-checking bench for capture_scheduler. Event times are
//                predicted from the refresh period and handshake delays.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_capture_scheduler;

  localparam int PERIOD_W = 20;
  localparam int SMP_TMO  = 512;
  localparam int FFT_TMO  = 128;
  localparam int TMO_W    = 16;

  logic                clk_25 = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic                smp_done = 1'b0;
  logic                fft_done = 1'b0;
  logic [PERIOD_W-1:0] frame_period = 100;
  logic                smp_start, fft_start, frame_valid, busy, err_tmo;
  logic [15:0]         frame_cnt;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          t0 = 0;
  int          per = 100;
  logic [15:0] exp_cnt = 16'd0;

  capture_scheduler #(
    .PERIOD_W (PERIOD_W),
    .SMP_TMO  (SMP_TMO),
    .FFT_TMO  (FFT_TMO),
    .TMO_W    (TMO_W)
  ) dut (
    .clk_25       (clk_25),
    .rst_n        (rst_n),
    .enable       (enable),
    .frame_period (frame_period),
    .smp_start    (smp_start),
    .smp_done     (smp_done),
    .fft_start    (fft_start),
    .fft_done     (fft_done),
    .frame_valid  (frame_valid),
    .busy         (busy),
    .err_tmo      (err_tmo),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk_25 = ~clk_25;
  always @(posedge clk_25) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return smp_start;
      1:       return fft_start;
      2:       return frame_valid;
      3:       return err_tmo;
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait for an output to be high at a falling edge; returns its cycle.
  task automatic wait_for(input int which, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_25);
      if (sig(which)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_timeout: signal %0d never rose within %0d cycles", which, limit);
    end
  endtask

  // Refresh ticks fall every max(period,2) cycles from the cycle enable rose.
  function automatic int next_tick(input int c);
    int pe;
    pe = (per < 2) ? 2 : per;
    if (c <= t0) return t0;
    return t0 + ((c - t0 + pe - 1) / pe) * pe;
  endfunction

  task automatic start_seg(input int p);
    per          = p;
    frame_period = PERIOD_W'(p);
    @(negedge clk_25);
    enable = 1'b1;
    t0     = cyc;
  endtask

  task automatic stop_seg();
    enable = 1'b0;
    repeat (3) @(negedge clk_25);
    check("idle_busy", busy, 0);
    check("idle_smp_start", smp_start, 0);
  endtask

  // One frame: sampler answers D cycles after start, engine F cycles after its pulse.
  task automatic run_frame(input int exp_rise, input int d_lat, input int f_lat,
                           input bit early, input bit drop_mid, output int pub);
    int s, d, f;
    wait_for(0, 3000, s);
    check("smp_rise_cyc", s, exp_rise);
    check("busy_in_frame", busy, 1);
    if (drop_mid) enable = 1'b0;
    repeat (d_lat) @(negedge clk_25);
    smp_done = 1'b1;
    d        = cyc;
    wait_for(1, SMP_TMO, f);
    check("fft_start_cyc", f, d + 3);
    check("smp_start_drop", smp_start, 0);
    if (early) fft_done = 1'b1;
    @(negedge clk_25);
    fft_done = 1'b0;
    smp_done = 1'b0;
    check("fft_start_width", fft_start, 0);
    check("no_early_publish", frame_valid, 0);
    while (cyc < f + f_lat) @(negedge clk_25);
    fft_done = 1'b1;
    @(negedge clk_25);
    fft_done = 1'b0;
    exp_cnt  = exp_cnt + 16'd1;
    check("frame_valid", frame_valid, 1);
    check("frame_cnt", frame_cnt, exp_cnt);
    check("no_err", err_tmo, 0);
    pub = cyc;
    @(negedge clk_25);
    check("frame_valid_width", frame_valid, 0);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pub, s, e, f, r;

    // Reset values
    repeat (3) @(negedge clk_25);
    check("rst_smp_start", smp_start, 0);
    check("rst_fft_start", fft_start, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_tmo, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_25);

    // Nominal: three frames, enable dropped during the last one
    start_seg(100);
    pub = t0 - 1;
    for (int k = 0; k < 3; k++)
      run_frame(next_tick(pub + 1) + 2, 300, 50, 1'b0, k == 2, pub);
    @(negedge clk_25);
    check("idle_after_drop", busy, 0);
    stop_seg();

    // Randomized periods (including the 0/1 clamp), latencies and early fft_done
    for (int sg = 0; sg < 3; sg++) begin
      start_seg(sg == 0 ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 150)));
      pub = t0 - 1;
      for (int k = 0; k < 3; k++)
        run_frame(next_tick(pub + 1) + 2, int'($urandom_range(1, 400)),
                  int'($urandom_range(1, 100)), 1'($urandom_range(0, 1)), 1'b0, pub);
      stop_seg();
    end

    // Stale done held across ARM entry
    smp_done = 1'b1;
    repeat (4) @(negedge clk_25);
    start_seg(50);
    repeat (20) begin
      @(negedge clk_25);
      check("stale_hold", smp_start, 0);
    end
    smp_done = 1'b0;
    r = cyc;
    run_frame(r + 3, 40, 10, 1'b0, 1'b0, pub);
    stop_seg();

    // Sampler timeout, then recovery through enable low
    start_seg(100);
    wait_for(0, 1000, s);
    check("tmo_smp_rise", s, t0 + 2);
    wait_for(3, SMP_TMO + 10, e);
    check("smp_tmo_cyc", e, s + SMP_TMO);
    check("tmo_smp_start", smp_start, 0);
    check("tmo_busy", busy, 0);
    repeat (50) @(negedge clk_25);
    check("err_sticky", err_tmo, 1);
    enable = 1'b0;
    repeat (2) @(negedge clk_25);
    check("err_cleared", err_tmo, 0);
    check("err_idle_busy", busy, 0);

    // Engine timeout
    start_seg(100);
    wait_for(0, 1000, s);
    repeat (10) @(negedge clk_25);
    smp_done = 1'b1;
    wait_for(1, SMP_TMO, f);
    @(negedge clk_25);
    smp_done = 1'b0;
    wait_for(3, FFT_TMO + 10, e);
    check("fft_tmo_cyc", e, f + FFT_TMO);
    enable = 1'b0;
    repeat (2) @(negedge clk_25);
    check("fft_err_cleared", err_tmo, 0);

    // Done rise lands on the last cycle before timeout: done must win
    start_seg(100);
    run_frame(t0 + 2, SMP_TMO - 3, 10, 1'b0, 1'b0, pub);
    stop_seg();

    // Counter wrap from 0xFFFF
    @(negedge clk_25);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk_25);
    release dut.frame_cnt_q;
    @(negedge clk_25);
    check("preload_cnt", frame_cnt, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    start_seg(60);
    run_frame(t0 + 2, 30, 5, 1'b0, 1'b0, pub);
    check("wrap_zero", frame_cnt, 0);
    stop_seg();

    // Asynchronous reset in the middle of WAIT_F
    start_seg(100);
    wait_for(0, 1000, s);
    repeat (10) @(negedge clk_25);
    smp_done = 1'b1;
    wait_for(1, SMP_TMO, f);
    @(negedge clk_25);
    smp_done = 1'b0;
    repeat (5) @(negedge clk_25);
    rst_n = 1'b0;
    #1;
    check("arst_smp_start", smp_start, 0);
    check("arst_fft_start", fft_start, 0);
    check("arst_frame_valid", frame_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err_tmo, 0);
    check("arst_frame_cnt", frame_cnt, 0);
    enable = 1'b0;
    @(negedge clk_25);
    rst_n   = 1'b1;
    exp_cnt = 16'd0;
    repeat (2) @(negedge clk_25);
    start_seg(80);
    run_frame(t0 + 2, 25, 8, 1'b0, 1'b0, pub);
    stop_seg();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
